// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the RX MAC filter: header constants, address
// types, filter FSM states and a small popcount helper.
package eth_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    typedef enum logic [1:0] {HDR0, HDR1, PASS, DROP} rx_filt_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_rx_filter_buf.sv
// Four-entry beat FIFO whose readable region ends at a commit pointer, so header
// beats can be held back and later released or discarded as one group.
module eth_rx_filter_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic [7:0]  push_keep,
    input  logic        push_last,
    input  logic        push_user,
    input  logic        commit,
    input  logic        drop_pending,
    output logic        full,
    output logic [63:0] out_data,
    output logic [7:0]  out_keep,
    output logic        out_last,
    output logic        out_user,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [63:0] mem_data [4];
    logic [7:0]  mem_keep [4];
    logic        mem_last [4];
    logic        mem_user [4];

    logic [2:0] wr_ptr;
    logic [2:0] commit_ptr;
    logic [2:0] rd_ptr;
    logic [2:0] wr_next;
    logic       pop;

    // Commit includes a beat written in the same cycle, so it is visible on the next one.
    always_comb begin
        full      = (wr_ptr[1:0] == rd_ptr[1:0]) && (wr_ptr[2] != rd_ptr[2]);
        out_valid = (commit_ptr != rd_ptr);
        pop       = out_valid && out_ready;
        wr_next   = wr_ptr + {2'd0, push};
        out_data  = mem_data[rd_ptr[1:0]];
        out_keep  = mem_keep[rd_ptr[1:0]];
        out_last  = mem_last[rd_ptr[1:0]];
        out_user  = mem_user[rd_ptr[1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= 3'd0;
            commit_ptr <= 3'd0;
            rd_ptr     <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_data[i] <= 64'd0;
                mem_keep[i] <= 8'd0;
                mem_last[i] <= 1'b0;
                mem_user[i] <= 1'b0;
            end
        end else begin
            if (push && !drop_pending) begin
                mem_data[wr_ptr[1:0]] <= push_data;
                mem_keep[wr_ptr[1:0]] <= push_keep;
                mem_last[wr_ptr[1:0]] <= push_last;
                mem_user[wr_ptr[1:0]] <= push_user;
            end
            wr_ptr <= drop_pending ? commit_ptr : wr_next;
            if (commit) begin
                commit_ptr <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_mac_filter.sv
// RX MAC filter: holds the first two beats of each frame until the destination
// MAC / EtherType decision, then forwards or drains the frame and counts it.
module eth_rx_mac_filter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic                    s_tuser,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser,
    input  logic [47:0]             cfg_local_mac,
    input  logic                    cfg_pass_bcast,
    input  logic                    cfg_pass_mcast,
    input  logic                    cfg_promisc,
    input  logic                    cfg_etype_en,
    input  logic [15:0]             cfg_etype,
    output logic [CNT_WIDTH-1:0]    cnt_pass,
    output logic [CNT_WIDTH-1:0]    cnt_drop,
    output logic [CNT_WIDTH-1:0]    cnt_runt
);

    if (DATA_WIDTH != 64) begin : g_width_check
        $error("eth_rx_mac_filter supports DATA_WIDTH=64 only");
    end

    rx_filt_state_t state;
    mac_addr_t      dst_reg;
    ethertype_t     etype;
    logic           hs;
    logic           hdr1_runt;
    logic           is_bcast;
    logic           is_mcast;
    logic           accept;
    logic           buf_push;
    logic           buf_commit;
    logic           buf_drop;
    logic           buf_full;

    // A beat-1 with fewer than the remaining header bytes makes the frame a runt.
    always_comb begin
        hs        = s_tvalid && s_tready;
        hdr1_runt = s_tlast && (popcount8(s_tkeep) < 4'(ETH_HDR_BYTES - 8));
        etype     = {s_tdata[39:32], s_tdata[47:40]};
        is_bcast  = (dst_reg == MAC_BCAST);
        is_mcast  = dst_reg[40] && !is_bcast;
        accept    = (cfg_promisc || (dst_reg == cfg_local_mac) ||
                     (is_bcast && cfg_pass_bcast) || (is_mcast && cfg_pass_mcast)) &&
                    (!cfg_etype_en || (etype == cfg_etype));
        s_tready  = rst ? 1'b0 : ((state == DROP) ? 1'b1 : !buf_full);

        buf_push   = 1'b0;
        buf_commit = 1'b0;
        buf_drop   = 1'b0;
        if (hs) begin
            case (state)
                HDR0: buf_push = !s_tlast;
                HDR1: begin
                    buf_push   = !hdr1_runt && accept;
                    buf_commit = !hdr1_runt && accept;
                    buf_drop   = hdr1_runt || !accept;
                end
                PASS: begin
                    buf_push   = 1'b1;
                    buf_commit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR0;
            dst_reg  <= '0;
            cnt_pass <= '0;
            cnt_drop <= '0;
            cnt_runt <= '0;
        end else if (hs) begin
            case (state)
                HDR0: begin
                    if (s_tlast) begin
                        cnt_runt <= cnt_runt + CNT_WIDTH'(1);
                    end else begin
                        dst_reg <= {s_tdata[7:0], s_tdata[15:8], s_tdata[23:16],
                                    s_tdata[31:24], s_tdata[39:32], s_tdata[47:40]};
                        state   <= HDR1;
                    end
                end
                HDR1: begin
                    if (hdr1_runt) begin
                        cnt_runt <= cnt_runt + CNT_WIDTH'(1);
                        state    <= HDR0;
                    end else if (accept) begin
                        if (s_tlast) begin
                            cnt_pass <= cnt_pass + CNT_WIDTH'(1);
                            state    <= HDR0;
                        end else begin
                            state <= PASS;
                        end
                    end else begin
                        cnt_drop <= cnt_drop + CNT_WIDTH'(1);
                        state    <= s_tlast ? HDR0 : DROP;
                    end
                end
                PASS: begin
                    if (s_tlast) begin
                        cnt_pass <= cnt_pass + CNT_WIDTH'(1);
                        state    <= HDR0;
                    end
                end
                DROP: begin
                    if (s_tlast) begin
                        state <= HDR0;
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end

    eth_rx_filter_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .push         (buf_push),
        .push_data    (s_tdata),
        .push_keep    (s_tkeep),
        .push_last    (s_tlast),
        .push_user    (s_tuser),
        .commit       (buf_commit),
        .drop_pending (buf_drop),
        .full         (buf_full),
        .out_data     (m_tdata),
        .out_keep     (m_tkeep),
        .out_last     (m_tlast),
        .out_user     (m_tuser),
        .out_valid    (m_tvalid),
        .out_ready    (m_tready)
    );

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Scoreboard bench for eth_rx_mac_filter: directed frames push expected output
// beats into a queue, and an independent monitor pops and compares them.
module tb_eth_rx_mac_filter;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MCAST_MAC = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] RAND_MAC  = 48'h0A_1B_2C_3D_4E_5F;
    localparam int CAT_PASS = 0;
    localparam int CAT_DROP = 1;
    localparam int CAT_RUNT = 2;

    logic        clk;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [47:0] cfg_local_mac;
    logic        cfg_pass_bcast;
    logic        cfg_pass_mcast;
    logic        cfg_promisc;
    logic        cfg_etype_en;
    logic [15:0] cfg_etype;
    logic [31:0] cnt_pass;
    logic [31:0] cnt_drop;
    logic [31:0] cnt_runt;

    int    total = 0;
    int    bad = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;
    int    exp_runt = 0;
    bit    rand_ready = 0;
    beat_t sb[$];

    eth_rx_mac_filter #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_tdata        (s_tdata),
        .s_tkeep        (s_tkeep),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .s_tuser        (s_tuser),
        .m_tdata        (m_tdata),
        .m_tkeep        (m_tkeep),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .cfg_local_mac  (cfg_local_mac),
        .cfg_pass_bcast (cfg_pass_bcast),
        .cfg_pass_mcast (cfg_pass_mcast),
        .cfg_promisc    (cfg_promisc),
        .cfg_etype_en   (cfg_etype_en),
        .cfg_etype      (cfg_etype),
        .cnt_pass       (cnt_pass),
        .cnt_drop       (cnt_drop),
        .cnt_runt       (cnt_runt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output backpressure changes only on falling edges.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat actual=%0h required=none", m_tdata);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_beat", {6'd0, m_tuser, m_tlast, m_tkeep, m_tdata},
                                {6'd0, e.u, e.l, e.k, e.d});
                end
            end
        end
    end

    function automatic logic [7:0] frame_byte(input logic [47:0] dst, input logic [15:0] et, input int idx);
        logic [47:0] src;
        src = 48'h02_11_22_33_44_55;
        if (idx < 6)  return dst[8*(5-idx) +: 8];
        if (idx < 12) return src[8*(11-idx) +: 8];
        if (idx == 12) return et[15:8];
        if (idx == 13) return et[7:0];
        return 8'((idx * 7 + 3) & 255);
    endfunction

    task automatic send_beat(input beat_t bt, output int waits);
        logic got;
        got   = 1'b0;
        waits = 0;
        s_tdata  = bt.d;
        s_tkeep  = bt.k;
        s_tlast  = bt.l;
        s_tuser  = bt.u;
        s_tvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #2;
            got = s_tready;
            @(negedge clk);
            if (got) break;
            waits++;
        end
        s_tvalid = 1'b0;
        checkOutput("s_handshake", {79'd0, got}, 80'd1);
    endtask

    // Sends one frame; abort_at >= 0 stops before that beat index.
    task automatic applyStimulus(input logic [47:0] dst, input logic [15:0] et, input int len,
                                 input int cat, input logic user, input bit lat_chk, input int abort_at);
        beat_t fr[$];
        beat_t bt;
        int    nb;
        int    waits;
        bit    drop_waited;
        nb = (len + 7) / 8;
        drop_waited = 0;
        for (int b = 0; b < nb; b++) begin
            bt.d = 64'd0;
            bt.k = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < len) begin
                    bt.d[8*j +: 8] = frame_byte(dst, et, b * 8 + j);
                    bt.k[j] = 1'b1;
                end
            end
            bt.l = (b == nb - 1);
            bt.u = (b == nb - 1) ? user : 1'b0;
            fr.push_back(bt);
            if (cat == CAT_PASS) sb.push_back(bt);
        end
        case (cat)
            CAT_PASS: exp_pass++;
            CAT_DROP: exp_drop++;
            default:  exp_runt++;
        endcase
        for (int b = 0; b < nb; b++) begin
            if (b == abort_at) return;
            send_beat(fr[b], waits);
            if (cat == CAT_DROP && b >= 2 && waits != 0) drop_waited = 1;
            if (lat_chk && b == 0) begin
                #1;
                checkOutput("hidden_beat0", {79'd0, m_tvalid}, 80'd0);
            end
            if (lat_chk && b == 1) begin
                #1;
                checkOutput("first_valid_latency", {79'd0, m_tvalid}, 80'd1);
            end
        end
        if (cat == CAT_DROP && nb > 2) checkOutput("drop_ready", {79'd0, drop_waited}, 80'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain", 80'(sb.size()), 80'd0);
        sb.delete();
    endtask

    task automatic check_counters(input string tag);
        checkOutput({tag, "_cnt_pass"}, {48'd0, cnt_pass}, 80'(exp_pass));
        checkOutput({tag, "_cnt_drop"}, {48'd0, cnt_drop}, 80'(exp_drop));
        checkOutput({tag, "_cnt_runt"}, {48'd0, cnt_runt}, 80'(exp_runt));
    endtask

    initial begin
        rst = 1'b1;
        s_tdata = 64'd0;
        s_tkeep = 8'd0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        cfg_local_mac = LOCAL_MAC;
        cfg_pass_bcast = 1'b0;
        cfg_pass_mcast = 1'b0;
        cfg_promisc = 1'b0;
        cfg_etype_en = 1'b0;
        cfg_etype = 16'h0800;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("reset_m_tvalid", {79'd0, m_tvalid}, 80'd0);
        checkOutput("reset_s_tready", {79'd0, s_tready}, 80'd0);
        check_counters("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle_s_tready", {79'd0, s_tready}, 80'd1);
        @(negedge clk);

        $display("[TB] local MAC 64B frame");
        applyStimulus(LOCAL_MAC, 16'h0800, 64, CAT_PASS, 1'b0, 1'b1, -1);
        wait_drain();
        check_counters("local");

        $display("[TB] foreign MAC dropped");
        applyStimulus(OTHER_MAC, 16'h0800, 64, CAT_DROP, 1'b0, 1'b0, -1);
        wait_drain();
        check_counters("foreign");

        $display("[TB] broadcast and EtherType filtering");
        applyStimulus(BCAST_MAC, 16'h0806, 60, CAT_DROP, 1'b0, 1'b0, -1);
        cfg_pass_bcast = 1'b1;
        applyStimulus(BCAST_MAC, 16'h0806, 60, CAT_PASS, 1'b0, 1'b0, -1);
        cfg_etype_en = 1'b1;
        applyStimulus(LOCAL_MAC, 16'h86DD, 64, CAT_DROP, 1'b0, 1'b0, -1);
        applyStimulus(LOCAL_MAC, 16'h0800, 60, CAT_PASS, 1'b0, 1'b0, -1);
        cfg_etype_en = 1'b0;
        wait_drain();
        check_counters("bcast_etype");

        $display("[TB] runts and the 14-byte boundary");
        applyStimulus(LOCAL_MAC, 16'h0800, 8, CAT_RUNT, 1'b0, 1'b0, -1);
        applyStimulus(LOCAL_MAC, 16'h0800, 12, CAT_RUNT, 1'b0, 1'b0, -1);
        applyStimulus(LOCAL_MAC, 16'h0800, 13, CAT_RUNT, 1'b0, 1'b0, -1);
        applyStimulus(LOCAL_MAC, 16'h0800, 14, CAT_PASS, 1'b0, 1'b0, -1);
        applyStimulus(LOCAL_MAC, 16'h0800, 64, CAT_PASS, 1'b0, 1'b0, -1);
        wait_drain();
        check_counters("runt");

        $display("[TB] multicast, promiscuous and error-flagged frames");
        applyStimulus(MCAST_MAC, 16'h0800, 60, CAT_DROP, 1'b0, 1'b0, -1);
        cfg_pass_mcast = 1'b1;
        applyStimulus(MCAST_MAC, 16'h0800, 60, CAT_PASS, 1'b0, 1'b0, -1);
        cfg_pass_mcast = 1'b0;
        applyStimulus(RAND_MAC, 16'h0800, 60, CAT_DROP, 1'b0, 1'b0, -1);
        cfg_promisc = 1'b1;
        applyStimulus(RAND_MAC, 16'h0800, 60, CAT_PASS, 1'b0, 1'b0, -1);
        cfg_promisc = 1'b0;
        applyStimulus(LOCAL_MAC, 16'h0800, 40, CAT_PASS, 1'b1, 1'b0, -1);
        wait_drain();
        check_counters("misc");

        $display("[TB] back-to-back 60B frames with random m_tready");
        rand_ready = 1;
        for (int f = 0; f < 10; f++) begin
            if (f % 3 == 2)
                applyStimulus(OTHER_MAC, 16'h0800, 60, CAT_DROP, 1'b0, 1'b0, -1);
            else
                applyStimulus(LOCAL_MAC, 16'(16'h0800 + f), 60, CAT_PASS, 1'b0, 1'b0, -1);
        end
        wait_drain();
        rand_ready = 0;
        @(negedge clk);
        check_counters("b2b");

        $display("[TB] reset during a passing frame");
        applyStimulus(LOCAL_MAC, 16'h0800, 64, CAT_PASS, 1'b0, 1'b0, 3);
        rst = 1'b1;
        #1;
        checkOutput("midrst_m_side", {6'd0, m_tuser, m_tlast, m_tkeep, m_tdata}, 80'd0);
        checkOutput("midrst_m_tvalid", {79'd0, m_tvalid}, 80'd0);
        checkOutput("midrst_s_tready", {79'd0, s_tready}, 80'd0);
        sb.delete();
        exp_pass = 0;
        exp_drop = 0;
        exp_runt = 0;
        check_counters("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(LOCAL_MAC, 16'h0800, 64, CAT_PASS, 1'b0, 1'b0, -1);
        wait_drain();
        check_counters("after_rst");

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
